rv32i: RTL and testbench
========================

Name: rv32i

Overview:
- Single-cycle RV32I integer core: one instruction fetched, decoded, executed and retired per rising clock edge.
- Contains instruction memory, register file, ALU, immediate generator, branch unit and data memory.
- Top of the processor; external pins are only clock and reset.
- The bench loads programs by writing instruction memory hierarchically and observes the PC and register file hierarchically.

Parameters:
- XLEN, 32, datapath and register width.
- IMEM_BYTES, 1024, instruction memory depth in byte addresses.
- DMEM_WORDS, 256, data memory depth in 32-bit words.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.

Behaviour:
- Mandatory hierarchy, accessed by benches:
  - Signal PC (32 b).
  - Instance IM holding array InstrMemory[0:IMEM_BYTES-1], 32 bits per entry, indexed by byte address. Instruction word n lives at entry 4n.
  - Instance RF holding array File[0:31] of XLEN bits.
- Reset, while rst=0:
  - PC=RESET_PC.
  - All RF.File entries cleared to 0.
  - IM and data memory untouched, so program contents survive reset.
- Fetch: instr = IM.InstrMemory[PC], combinational.
  - Memory written hierarchically before the next rising edge is executed on that edge.
  - PC outside IM range reads 0.
  - All-zero word decodes as illegal and executes as a NOP.
- Per rising edge:
  - One register writeback.
  - One optional data-memory word write.
  - PC update: PC+4 by default; branch/JAL target = PC+imm; JALR target = (rs1+imm) with bit0 cleared.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - x0 reads 0; writes to x0 are ignored.
  - Read during write returns the old value.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU.
  - SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- FENCE, ECALL, EBREAK and any unrecognised opcode: NOP (PC+4, no writes).
- Arithmetic:
  - Modulo 2^32 wrap, no overflow traps.
  - Shift amount = low 5 bits of operand B.
  - SLT/BLT signed; SLTU/BLTU unsigned.
- Immediates: I/S/B/U/J formats sign-extended per the RV32I spec.
- JAL/JALR write PC+4 to rd.
- Data memory, word-addressed by addr[9:2]:
  - Byte/half accesses use addr[1:0] lanes, little-endian.
  - Loads sign- or zero-extend per funct3.
  - Stores write only the selected lanes.
  - Reads are combinational.
  - Misaligned accesses ignore the low address bits (no trap).
- Branch to self: the core spins; this is legal and how programs halt.

Decomposition:
- Shared package rv32i_pkg:
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP).
  - funct3/funct7 constants.
  - alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB).
  - imm_sel_e enum.
- Sub-modules:
  - Register file, instance name RF, 32x32 with async clear.
  - Instruction memory, instance name IM, a plain array with a combinational read.
  - Decoder, ALU and data memory stay in the top level.

Test Plan:
- Multiply by repeated addition: x1=6, x2=7, loop accumulating x1 into x6 while decrementing x2 with BNE, then ADDI x7,x0,1 and self-branch → PC passes 8 with x1=6, x2=7; final x6=42, x7=1.
- Divide by repeated subtraction: x1=100, x2=7, loop with SUB/BGE counting into x6, then x7=1 → x6=14. Repeat with x1=21, x2=7 → x6=3.
- Back-to-back programs: after a run ends with x7=1, pulse rst low for 1 ns and load a new program → all registers read 0 immediately, PC=0, the new program runs to its own result, and x7 is not stale.
- x0 and immediates: ADDI x0,x0,5; LUI x3,0xFFFFF; ADDI x4,x0,-1; SRAI x5,x4,4; SRLI x8,x4,28 → x0=0, x3=0xFFFFF000, x4=0xFFFFFFFF, x5=0xFFFFFFFF, x8=0xF.
- Memory: ADDI x1,x0,-128; SW x1,0(x0); LB x2,0(x0); LBU x3,0(x0); SB x0,1(x0); LW x4,0(x0) → x2=0xFFFFFF80, x3=0x80, x4=0xFFFF0080.
- Control flow: JAL x1,+8 at PC=0 → x1=4, PC=8. JALR x2,0(x1) → PC=4, x2=12. BLTU with x5=0xFFFFFFFF vs 1 is not taken; BLT with the same operands is taken.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, control enums and immediate generation for the rv32i core.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers decide when funct7 is allowed to set it
  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_imem.sv
// Byte-addressed instruction store; contents are loaded from outside and never reset.
module rv32i_imem #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [31:0] InstrMemory [0:IMEM_BYTES-1];

  assign instr_o = (addr_i < 32'(IMEM_BYTES)) ? InstrMemory[addr_i[AW-1:0]] : '0;

endmodule

// File: rtl/rv32i_regfile.sv
// 32-entry register file: two combinational reads, one synchronous write, async clear.
module rv32i_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i
);

  logic [XLEN-1:0] File [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) File[i] <= '0;
    end else if (we_i && (rd_addr_i != 5'd0)) begin
      File[rd_addr_i] <= rd_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : File[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : File[rs2_addr_i];

endmodule

// File: rtl/rv32i.sv
// Single-cycle RV32I core: decode, ALU, branch unit and data memory, with RF and IM sub-blocks.
module rv32i
  import rv32i_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_BYTES = 1024,
  parameter int              DMEM_WORDS = 256,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic clk,
  input logic rst
);

  localparam int DAW = $clog2(DMEM_WORDS);

  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] pc_d, pc_plus4, pc_target;
  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;

  alu_op_e  alu_op;
  imm_sel_e imm_sel;
  wb_sel_e  wb_sel;
  logic     a_pc, b_imm, reg_we, mem_we, is_branch, is_jal, is_jalr;

  logic [XLEN-1:0] imm, rs1_data, rs2_data, alu_a, alu_b, alu_res, wb_data;
  logic [4:0]      shamt;
  logic            br_take;

  logic [XLEN-1:0] dmem [0:DMEM_WORDS-1];
  logic [DAW-1:0]  dmem_idx;
  logic [XLEN-1:0] dmem_rdata, ld_data, st_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [3:0]      st_be;

  rv32i_imem #(.IMEM_BYTES(IMEM_BYTES)) IM (
    .addr_i  (PC),
    .instr_o (instr)
  );

  rv32i_regfile #(.XLEN(XLEN)) RF (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (reg_we),
    .rd_addr_i  (rd),
    .rd_data_i  (wb_data)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Anything not matched below (FENCE, SYSTEM, zero word, bad funct) retires as a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    wb_sel    = WB_ALU;
    a_pc      = 1'b0;
    b_imm     = 1'b1;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_sel = IMM_U;
        alu_op  = ALU_PASSB;
        reg_we  = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U;
        a_pc    = 1'b1;
        reg_we  = 1'b1;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        wb_sel  = WB_PC4;
        is_jal  = 1'b1;
        reg_we  = 1'b1;
      end
      OP_JALR: begin
        wb_sel  = WB_PC4;
        is_jalr = (funct3 == 3'b000);
        reg_we  = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        imm_sel   = IMM_B;
        is_branch = (funct3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        wb_sel = WB_MEM;
        reg_we = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      OP_STORE: begin
        imm_sel = IMM_S;
        mem_we  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end
      OP_IMM: begin
        alu_op = f3_alu(funct3, (funct3 == F3_SR) && instr[30]);
        if (funct3 == F3_SLL)     reg_we = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) reg_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                      reg_we = 1'b1;
      end
      OP_OP: begin
        b_imm  = 1'b0;
        alu_op = f3_alu(funct3, funct7[5]);
        reg_we = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      default: ;
    endcase
  end

  assign imm   = gen_imm(instr, imm_sel);
  assign alu_a = a_pc ? PC : rs1_data;
  assign alu_b = b_imm ? imm : rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:   alu_res = alu_a + alu_b;
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_SLL:   alu_res = alu_a << shamt;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SRL:   alu_res = alu_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      F3_BEQ:  br_take = (rs1_data == rs2_data);
      F3_BNE:  br_take = (rs1_data != rs2_data);
      F3_BLT:  br_take = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  br_take = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_take = (rs1_data < rs2_data);
      F3_BGEU: br_take = (rs1_data >= rs2_data);
      default: br_take = 1'b0;
    endcase
  end

  assign pc_plus4  = PC + 4;
  assign pc_target = PC + imm;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal || (is_branch && br_take)) pc_d = pc_target;
    else if (is_jalr)                     pc_d = {alu_res[XLEN-1:1], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) PC <= RESET_PC;
    else      PC <= pc_d;
  end

  // Word-indexed data memory; the low two address bits only steer byte lanes.
  assign dmem_idx   = alu_res[DAW+1:2];
  assign dmem_rdata = dmem[dmem_idx];
  assign ld_byte    = dmem_rdata[{alu_res[1:0], 3'b000} +: 8];
  assign ld_half    = alu_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B: begin
        st_data = {4{rs2_data[7:0]}};
        st_be   = 4'b0001 << alu_res[1:0];
      end
      F3_H: begin
        st_data = {2{rs2_data[15:0]}};
        st_be   = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = rs2_data;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) dmem[dmem_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = ld_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

endmodule

// File: tb/tb_rv32i.sv
// Program-level bench for rv32i: loads small programs into IM and scores final register state.
`timescale 1ns/1ps
module tb_rv32i;

  logic clk;
  logic rst;

  rv32i dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          r;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoders (literal ISA encodings) ----------------
  function automatic logic [31:0] op_i(input logic [2:0] f3, input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] op_r(input logic [6:0] f7, input logic [2:0] f3, input int rd,
                                       input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] ld(input logic [2:0] f3, input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), 7'h03};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] f3, input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), f3, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h67};
  endfunction

  function automatic logic [31:0] op_u(input logic [6:0] op, input int rd, input int imm20);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] halt();
    return br(3'b000, 0, 0, 0);
  endfunction

  // ---------------- program control ----------------
  task automatic expect_reg(input string tag, input int r, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.r   = r;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Reset pulse of 1 ns; the program is written while reset is asserted.
  task automatic start_prog(input string tag);
    logic [31:0] any;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 1024; a++) dut.IM.InstrMemory[a] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.IM.InstrMemory[4*i] = prog[i];
    prog.delete();
    #0.5;
    any = '0;
    for (int r = 0; r < 32; r++) any = any | dut.RF.File[r];
    check({tag, "_rf_clear"}, any, 32'h0);
    check({tag, "_pc_reset"}, dut.PC, 32'h0);
    #0.5;
    rst = 1'b1;
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
    int n;
    n = 0;
    while (dut.PC !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halt_pc"}, dut.PC, target);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, dut.RF.File[e.r], e.v);
    end
  endtask

  task automatic div_prog(input int dividend);
    prog.push_back(op_i(3'b000, 1, 0, dividend));
    prog.push_back(op_i(3'b000, 2, 0, 7));
    prog.push_back(op_r(7'h20, 3'b000, 1, 1, 2));
    prog.push_back(op_i(3'b000, 6, 6, 1));
    prog.push_back(br(3'b101, 1, 2, -8));
    prog.push_back(op_i(3'b000, 7, 0, 1));
    prog.push_back(halt());
  endtask

  initial begin
    rst = 1'b1;

    // multiply by repeated addition
    prog.push_back(op_i(3'b000, 1, 0, 6));
    prog.push_back(op_i(3'b000, 2, 0, 7));
    prog.push_back(op_r(7'h00, 3'b000, 6, 6, 1));
    prog.push_back(op_i(3'b000, 2, 2, -1));
    prog.push_back(br(3'b001, 2, 0, -8));
    prog.push_back(op_i(3'b000, 7, 0, 1));
    prog.push_back(halt());
    expect_reg("mul_x6", 6, 32'd42);
    expect_reg("mul_x7", 7, 32'd1);
    expect_reg("mul_x2", 2, 32'd0);
    start_prog("mul");
    repeat (2) @(negedge clk);
    check("mul_pc8", dut.PC, 32'd8);
    check("mul_pc8_x1", dut.RF.File[1], 32'd6);
    check("mul_pc8_x2", dut.RF.File[2], 32'd7);
    wait_pc("mul", 32'd24, 200);
    drain();

    // divide 100/7, then back-to-back 21/7
    div_prog(100);
    expect_reg("div100_x6", 6, 32'd14);
    expect_reg("div100_x1", 1, 32'd2);
    expect_reg("div100_x7", 7, 32'd1);
    start_prog("div100");
    wait_pc("div100", 32'd24, 300);
    drain();

    div_prog(21);
    expect_reg("div21_x6", 6, 32'd3);
    expect_reg("div21_x1", 1, 32'd0);
    expect_reg("div21_x7", 7, 32'd1);
    start_prog("div21");
    repeat (3) @(negedge clk);
    check("div21_x7_fresh", dut.RF.File[7], 32'd0);
    wait_pc("div21", 32'd24, 300);
    drain();

    // x0 and immediates
    prog.push_back(op_i(3'b000, 0, 0, 5));
    prog.push_back(op_u(7'h37, 3, 20'hFFFFF));
    prog.push_back(op_i(3'b000, 4, 0, -1));
    prog.push_back(op_i(3'b101, 5, 4, 12'h404));
    prog.push_back(op_i(3'b101, 8, 4, 28));
    prog.push_back(halt());
    expect_reg("imm_x0", 0, 32'h0);
    expect_reg("imm_x3", 3, 32'hFFFFF000);
    expect_reg("imm_x4", 4, 32'hFFFFFFFF);
    expect_reg("imm_x5", 5, 32'hFFFFFFFF);
    expect_reg("imm_x8", 8, 32'h0000000F);
    start_prog("imm");
    wait_pc("imm", 32'd20, 50);
    drain();

    // data memory lanes and extension
    prog.push_back(op_i(3'b000, 1, 0, -128));
    prog.push_back(st(3'b010, 1, 0, 0));
    prog.push_back(ld(3'b000, 2, 0, 0));
    prog.push_back(ld(3'b100, 3, 0, 0));
    prog.push_back(st(3'b000, 0, 0, 1));
    prog.push_back(ld(3'b010, 4, 0, 0));
    prog.push_back(ld(3'b001, 5, 0, 2));
    prog.push_back(ld(3'b101, 9, 0, 2));
    prog.push_back(halt());
    expect_reg("mem_lb", 2, 32'hFFFFFF80);
    expect_reg("mem_lbu", 3, 32'h00000080);
    expect_reg("mem_sb_lw", 4, 32'hFFFF0080);
    expect_reg("mem_lh_hi", 5, 32'hFFFFFFFF);
    expect_reg("mem_lhu_hi", 9, 32'h0000FFFF);
    start_prog("mem");
    wait_pc("mem", 32'd32, 50);
    drain();

    // control flow
    prog.push_back(jal(1, 8));
    prog.push_back(jal(0, 12));
    prog.push_back(jalr(2, 1, 0));
    prog.push_back(op_i(3'b000, 10, 0, 99));
    prog.push_back(op_i(3'b000, 5, 0, -1));
    prog.push_back(op_i(3'b000, 6, 0, 1));
    prog.push_back(br(3'b110, 5, 6, 8));
    prog.push_back(op_i(3'b000, 11, 0, 1));
    prog.push_back(br(3'b100, 5, 6, 8));
    prog.push_back(op_i(3'b000, 12, 0, 1));
    prog.push_back(op_i(3'b000, 13, 0, 1));
    prog.push_back(halt());
    expect_reg("ctl_x10_skipped", 10, 32'd0);
    expect_reg("ctl_bltu_not_taken", 11, 32'd1);
    expect_reg("ctl_blt_taken", 12, 32'd0);
    expect_reg("ctl_x13", 13, 32'd1);
    start_prog("ctl");
    @(negedge clk);
    check("ctl_jal_pc", dut.PC, 32'd8);
    check("ctl_jal_x1", dut.RF.File[1], 32'd4);
    @(negedge clk);
    check("ctl_jalr_pc", dut.PC, 32'd4);
    check("ctl_jalr_x2", dut.RF.File[2], 32'd12);
    wait_pc("ctl", 32'd44, 50);
    drain();

    // ALU coverage, illegal zero word and ECALL as NOPs
    prog.push_back(op_i(3'b000, 1, 0, -5));
    prog.push_back(op_i(3'b000, 2, 0, 3));
    prog.push_back(op_r(7'h00, 3'b000, 3, 1, 2));
    prog.push_back(op_r(7'h20, 3'b000, 4, 2, 1));
    prog.push_back(op_r(7'h00, 3'b010, 5, 1, 2));
    prog.push_back(op_r(7'h00, 3'b011, 6, 1, 2));
    prog.push_back(op_r(7'h00, 3'b100, 7, 1, 2));
    prog.push_back(op_r(7'h00, 3'b110, 8, 1, 2));
    prog.push_back(op_r(7'h00, 3'b111, 9, 1, 2));
    prog.push_back(op_r(7'h00, 3'b001, 10, 2, 2));
    prog.push_back(op_r(7'h20, 3'b101, 11, 1, 2));
    prog.push_back(op_r(7'h00, 3'b101, 12, 1, 2));
    prog.push_back(op_i(3'b010, 13, 1, -4));
    prog.push_back(op_i(3'b011, 14, 2, -1));
    prog.push_back(op_i(3'b100, 15, 2, -1));
    prog.push_back(op_i(3'b111, 16, 1, 12'h0F0));
    prog.push_back(op_i(3'b110, 17, 2, 12'h100));
    prog.push_back(op_u(7'h17, 18, 1));
    prog.push_back(op_i(3'b001, 19, 2, 31));
    prog.push_back(32'h00000000);
    prog.push_back(32'h00000073);
    prog.push_back(op_i(3'b000, 20, 0, 7));
    prog.push_back(halt());
    expect_reg("alu_add", 3, 32'hFFFFFFFE);
    expect_reg("alu_sub", 4, 32'd8);
    expect_reg("alu_slt", 5, 32'd1);
    expect_reg("alu_sltu", 6, 32'd0);
    expect_reg("alu_xor", 7, 32'hFFFFFFF8);
    expect_reg("alu_or", 8, 32'hFFFFFFFB);
    expect_reg("alu_and", 9, 32'd3);
    expect_reg("alu_sll", 10, 32'd24);
    expect_reg("alu_sra", 11, 32'hFFFFFFFF);
    expect_reg("alu_srl", 12, 32'h1FFFFFFF);
    expect_reg("alu_slti", 13, 32'd1);
    expect_reg("alu_sltiu", 14, 32'd1);
    expect_reg("alu_xori", 15, 32'hFFFFFFFC);
    expect_reg("alu_andi", 16, 32'h000000F0);
    expect_reg("alu_ori", 17, 32'h00000103);
    expect_reg("alu_auipc", 18, 32'h00001044);
    expect_reg("alu_slli", 19, 32'h80000000);
    expect_reg("alu_after_nops", 20, 32'd7);
    start_prog("alu");
    wait_pc("alu", 32'd88, 100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
